// File: rtl/rr_decode_arbiter.sv
// Four-requester round-robin arbiter driving a 2-to-4 decoder. The grant index,
// grant-valid and decoded one-hot grant are all registered; a hold counter caps tenure.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic [3:0] gnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       gnt_idx_q;
  logic             gnt_valid_q;
  logic [3:0]       gnt_q;
  logic [CNT_W-1:0] hold_cnt_q;

  logic [1:0] holder;
  logic [3:0] holder_mask;
  logic       lost_req;
  logic       timeout;
  logic       rel_hit;
  logic [3:0] cand;
  logic [1:0] idle_pick_d;
  logic [1:0] hand_pick_d;

  // First set bit of v scanning start, start+1, ... with modulo-4 wrap.
  function automatic logic [1:0] arb(input logic [3:0] v, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (v[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    holder      = gnt_idx_q;
    holder_mask = decode(holder);
    lost_req    = ~|(req & holder_mask);
    timeout     = (hold_cnt_q == CNT_W'(MAX_HOLD));
    rel_hit     = !en || done || lost_req || timeout;
    // A finished or withdrawn holder is excluded; a timed-out one only drops to lowest priority.
    cand        = (done || lost_req) ? (req & ~holder_mask) : req;
    idle_pick_d = arb(req, ptr_q);
    hand_pick_d = arb(cand, holder + 2'd1);
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      gnt_q       <= 4'b0000;
      hold_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && |req) begin
            gnt_idx_q   <= idle_pick_d;
            gnt_q       <= decode(idle_pick_d);
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= CNT_W'(1);
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          if (rel_hit) begin
            ptr_q <= holder + 2'd1;
            if (en && |cand) begin
              gnt_idx_q  <= hand_pick_d;
              gnt_q      <= decode(hand_pick_d);
              hold_cnt_q <= CNT_W'(1);
            end else begin
              gnt_valid_q <= 1'b0;
              gnt_q       <= 4'b0000;
              state_q     <= IDLE;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt       = gnt_q;

endmodule
